// File: rtl/res_fifo_param_if.sv
// Handshake/status bundle between the result FIFO and its writer/reader.
// master drives requests and write data; slave (the FIFO) returns read data and status.
interface res_fifo_param_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1352,
  parameter int CNT_W  = $clog2(DEPTH + 1)
);
  logic              clear;
  logic              wenable;
  logic [DATA_W-1:0] wdata;
  logic              renable;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              almost_empty;
  logic              almost_full;
  logic              overflow;
  logic              underflow;

  modport master (
    output clear, wenable, wdata, renable,
    input  rdata, rvalid, count, empty, full, almost_empty, almost_full, overflow, underflow
  );

  modport slave (
    input  clear, wenable, wdata, renable,
    output rdata, rvalid, count, empty, full, almost_empty, almost_full, overflow, underflow
  );
endinterface

// File: rtl/res_fifo_param.sv
// Result FIFO, any DEPTH >= 2; registered read (rvalid one cycle after accepted renable).
// No backpressure beyond full/empty: rejected requests set sticky overflow/underflow.
module res_fifo_param #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 1352,
  parameter int AFULL_TH  = DEPTH - 4,
  parameter int AEMPTY_TH = 4,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            n_rst,
  res_fifo_param_if.slave bus
);
  localparam int AW       = $clog2(DEPTH);
  localparam int AF_CLAMP = (AFULL_TH < 0) ? 0 : AFULL_TH;
  localparam int AE_CLAMP = (AEMPTY_TH < 0) ? 0 : AEMPTY_TH;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [AW-1:0]     waddr_q, waddr_d;
  logic [AW-1:0]     raddr_q, raddr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;

  logic empty, full, rd_ok, wr_ok;

  // Pointers wrap on an explicit compare so non-power-of-2 depths work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  // A read frees a slot in the same cycle, so a full FIFO still takes a write alongside it.
  assign rd_ok = bus.renable & ~empty;
  assign wr_ok = bus.wenable & (~full | rd_ok);

  always_comb begin
    waddr_d  = waddr_q;
    raddr_d  = raddr_q;
    count_d  = count_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    ovf_d    = ovf_q;
    udf_d    = udf_q;

    if (bus.clear) begin
      waddr_d = '0;
      raddr_d = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      if (wr_ok) begin
        waddr_d = ptr_inc(waddr_q);
      end
      if (rd_ok) begin
        raddr_d  = ptr_inc(raddr_q);
        rdata_d  = mem_q[raddr_q];
        rvalid_d = 1'b1;
      end
      unique case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (bus.wenable & ~wr_ok) begin
        ovf_d = 1'b1;
      end
      if (bus.renable & ~rd_ok) begin
        udf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      waddr_q  <= '0;
      raddr_q  <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      waddr_q  <= waddr_d;
      raddr_q  <= raddr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is deliberately unreset.
  always_ff @(posedge clk) begin
    if (!bus.clear && wr_ok) begin
      mem_q[waddr_q] <= bus.wdata;
    end
  end

  assign bus.rdata        = rdata_q;
  assign bus.rvalid       = rvalid_q;
  assign bus.count        = count_q;
  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.almost_empty = (AEMPTY_TH >= 0) && (count_q <= CNT_W'(AE_CLAMP));
  assign bus.almost_full  = (AFULL_TH <= DEPTH) && (count_q >= CNT_W'(AF_CLAMP));
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_res_fifo_param.sv
// Randomised + directed bench for res_fifo_param against a queue-based reference model.
module tb_res_fifo_param;
  localparam int DEPTH = 6;
  localparam int AF    = 5;
  localparam int AE    = 2;

  logic clk = 1'b0;
  logic n_rst;

  always #5 clk = ~clk;

  res_fifo_param_if #(.DATA_W(16), .DEPTH(DEPTH)) bus ();

  res_fifo_param #(
    .DATA_W   (16),
    .DEPTH    (DEPTH),
    .AFULL_TH (AF),
    .AEMPTY_TH(AE)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic [15:0] mq[$];
  logic [15:0] exp_q[$];
  logic        e_ovf, e_udf, e_rv;
  logic [15:0] e_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    e_ovf = 1'b0;
    e_udf = 1'b0;
    e_rv  = 1'b0;
    e_rd  = 16'h0;
  endtask

  task automatic check_status(input string tag);
    int n;
    n = mq.size();
    chk({tag, ":count"},     32'(bus.count),        32'(n));
    chk({tag, ":empty"},     32'(bus.empty),        32'(n == 0));
    chk({tag, ":full"},      32'(bus.full),         32'(n == DEPTH));
    chk({tag, ":aempty"},    32'(bus.almost_empty), 32'(n <= AE));
    chk({tag, ":afull"},     32'(bus.almost_full),  32'(n >= AF));
    chk({tag, ":overflow"},  32'(bus.overflow),     32'(e_ovf));
    chk({tag, ":underflow"}, 32'(bus.underflow),    32'(e_udf));
    chk({tag, ":rvalid"},    32'(bus.rvalid),       32'(e_rv));
    chk({tag, ":rdata"},     32'(bus.rdata),        32'(e_rd));
  endtask

  // Drive one cycle of requests (called at posedge+1), advance the model, check after the edge.
  task automatic step(input string tag, input logic c, input logic we, input logic [15:0] wd,
                      input logic re);
    logic rd, wr;
    bus.clear   = c;
    bus.wenable = we;
    bus.wdata   = wd;
    bus.renable = re;
    if (c) begin
      mq.delete();
      e_ovf = 1'b0;
      e_udf = 1'b0;
      e_rv  = 1'b0;
    end else begin
      rd   = re && (mq.size() != 0);
      wr   = we && ((mq.size() < DEPTH) || rd);
      e_rv = rd;
      if (rd) begin
        e_rd = mq.pop_front();
        exp_q.push_back(e_rd);
      end
      if (wr) mq.push_back(wd);
      if (we && !wr) e_ovf = 1'b1;
      if (re && !rd) e_udf = 1'b1;
    end
    @(posedge clk);
    #1;
    check_status(tag);
  endtask

  // Scoreboard monitor: every presented read word must match the next expected one.
  always @(negedge clk) begin
    if (n_rst && bus.rvalid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL rd_spurious: got %0h expected no read", bus.rdata);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (bus.rdata !== e) begin
          n_bad++;
          $display("FAIL rd_data: got %0h expected %0h", bus.rdata, e);
        end
      end
    end
  end

  initial begin
    bus.clear   = 1'b0;
    bus.wenable = 1'b0;
    bus.wdata   = 16'h0;
    bus.renable = 1'b0;
    n_rst = 1'b1;
    model_reset();
    #1 n_rst = 1'b0;
    #20;
    check_status("reset");
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < DEPTH; i++) step("fill", 1'b0, 1'b1, 16'(i + 1), 1'b0);
    chk("fill_full", 32'(bus.full), 32'd1);
    step("overwrite", 1'b0, 1'b1, 16'hDEAD, 1'b0);
    chk("overflow_set", 32'(bus.overflow), 32'd1);
    for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 1'b0, 16'h0, 1'b1);
    step("rd_empty", 1'b0, 1'b0, 16'h0, 1'b1);
    chk("underflow_set", 32'(bus.underflow), 32'd1);
    step("clear1", 1'b1, 1'b0, 16'h0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      step("wrap_w", 1'b0, 1'b1, 16'(16'h00A0 + i), 1'b0);
      step("wrap_r", 1'b0, 1'b0, 16'h0, 1'b1);
    end

    for (int i = 0; i < DEPTH; i++) step("fill2", 1'b0, 1'b1, 16'(16'h0100 + i), 1'b0);
    step("full_rw", 1'b0, 1'b1, 16'hBEEF, 1'b1);
    for (int i = 0; i < DEPTH; i++) step("drain2", 1'b0, 1'b0, 16'h0, 1'b1);
    step("lastword", 1'b0, 1'b0, 16'h0, 1'b0);
    chk("beef_last", 32'(bus.rdata), 32'h0000BEEF);

    step("clear2", 1'b1, 1'b0, 16'h0, 1'b0);
    step("empty_rw", 1'b0, 1'b1, 16'h1234, 1'b1);
    step("rd_1234", 1'b0, 1'b0, 16'h0, 1'b1);

    for (int i = 0; i < 3; i++) step("fill3", 1'b0, 1'b1, 16'(16'h0200 + i), 1'b0);
    step("clear_w", 1'b1, 1'b1, 16'h5555, 1'b1);

    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 39) == 0), ($urandom_range(0, 99) < 55), 16'($urandom),
           ($urandom_range(0, 99) < 50));
    end

    for (int i = 0; i < 3; i++) step("burst", 1'b0, 1'b1, 16'(16'h0300 + i), 1'b0);
    step("burst_rw", 1'b0, 1'b1, 16'h0303, 1'b1);
    #2;
    n_rst = 1'b0;
    bus.wenable = 1'b0;
    bus.renable = 1'b0;
    bus.clear   = 1'b0;
    #1;
    model_reset();
    check_status("async_rst");
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    step("post_rst_w", 1'b0, 1'b1, 16'h4321, 1'b0);
    step("post_rst_r", 1'b0, 1'b0, 16'h0, 1'b1);
    step("idle", 1'b0, 1'b0, 16'h0, 1'b0);
    step("idle", 1'b0, 1'b0, 16'h0, 1'b0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
